// File: rtl/bus_grant_seq.sv
// Bus grant sequencer: pops one sender ID from the request queue, grants that
// agent one-hot bus ownership until release or timeout, then one turnaround cycle.
module bus_grant_seq #(
    parameter int NAGENT  = 16,
    parameter int IDW     = 4,
    parameter int TIMEOUT = 32,
    parameter int CNTW    = 8
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              en,
    input  logic              valid,
    input  logic              empty,
    input  logic [IDW-1:0]    send_in,
    input  logic [NAGENT-1:0] release_req,
    input  logic              err_clr,
    output logic              pull,
    output logic [NAGENT-1:0] grant,
    output logic [IDW-1:0]    owner,
    output logic              bus_busy,
    output logic              bus_idle,
    output logic              timeout_err,
    output logic [CNTW-1:0]   xfer_cnt
);

    localparam int TCW = $clog2(TIMEOUT);
    localparam logic [TCW-1:0] TMAX = TCW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_TURN
    } state_t;

    state_t         state, state_nxt;
    logic [TCW-1:0] tcnt;
    logic           to_hit;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        pull      = 1'b0;
        to_hit    = 1'b0;
        case (state)
            // clr gates pull so the pop strobe drops the moment reset asserts
            S_IDLE: begin
                if (valid && en && clr) begin
                    pull      = 1'b1;
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (release_req[owner]) begin
                    state_nxt = S_TURN;
                end else if (tcnt == TMAX) begin
                    to_hit    = 1'b1;
                    state_nxt = S_TURN;
                end
            end
            S_TURN:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state       <= S_IDLE;
            grant       <= '0;
            owner       <= '0;
            timeout_err <= 1'b0;
            xfer_cnt    <= '0;
            tcnt        <= '0;
        end else begin
            state <= state_nxt;
            if (pull) begin
                owner    <= send_in;
                grant    <= NAGENT'(1) << send_in;
                tcnt     <= '0;
                xfer_cnt <= xfer_cnt + CNTW'(1);
            end else if (state == S_GRANT) begin
                if (state_nxt == S_TURN) begin
                    grant <= '0;
                end else begin
                    tcnt <= tcnt + TCW'(1);
                end
            end
            // a timeout on the same edge as err_clr leaves the flag set
            if (to_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

    assign bus_busy = (state != S_IDLE);
    assign bus_idle = (state == S_IDLE) && empty;

endmodule

// File: tb/tb_bus_grant_seq.sv
// Directed testbench for bus_grant_seq: one task per scenario, each with
// hand-computed expectations checked inline.
module tb_bus_grant_seq;

    logic        clk = 1'b0;
    logic        clr;
    logic        en;
    logic        valid;
    logic        empty;
    logic [3:0]  send_in;
    logic [15:0] release_req;
    logic        err_clr;
    logic        pull;
    logic [15:0] grant;
    logic [3:0]  owner;
    logic        bus_busy;
    logic        bus_idle;
    logic        timeout_err;
    logic [7:0]  xfer_cnt;

    int checks   = 0;
    int failures = 0;

    bus_grant_seq #(.NAGENT(16), .IDW(4), .TIMEOUT(32), .CNTW(8)) dut (
        .clk(clk), .clr(clr), .en(en), .valid(valid), .empty(empty),
        .send_in(send_in), .release_req(release_req), .err_clr(err_clr),
        .pull(pull), .grant(grant), .owner(owner), .bus_busy(bus_busy),
        .bus_idle(bus_idle), .timeout_err(timeout_err), .xfer_cnt(xfer_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b0; en = 1'b1; valid = 1'b0; empty = 1'b1;
        send_in = '0; release_req = '0; err_clr = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        clr = 1'b0; en = 1'b1; valid = 1'b1; empty = 1'b1;
        send_in = 4'h3; release_req = '0; err_clr = 1'b0;
        #2;
        checks++; if (pull !== 1'b0) begin failures++; $display("FAIL reset_pull: got %b expected 0", pull); end
        checks++; if (grant !== 16'h0000) begin failures++; $display("FAIL reset_grant: got %h expected 0000", grant); end
        checks++; if (owner !== 4'h0) begin failures++; $display("FAIL reset_owner: got %h expected 0", owner); end
        checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus_busy); end
        checks++; if (bus_idle !== 1'b1) begin failures++; $display("FAIL reset_idle: got %b expected 1", bus_idle); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_err: got %b expected 0", timeout_err); end
        checks++; if (xfer_cnt !== 8'd0) begin failures++; $display("FAIL reset_cnt: got %0d expected 0", xfer_cnt); end
        valid = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        tick();
    endtask

    task automatic test_single_grant();
        valid = 1'b1; send_in = 4'h6;
        #1;
        checks++; if (pull !== 1'b1) begin failures++; $display("FAIL single_pull: got %b expected 1", pull); end
        tick();
        valid = 1'b0;
        #1;
        checks++; if (grant !== 16'h0040) begin failures++; $display("FAIL single_grant: got %h expected 0040", grant); end
        checks++; if (owner !== 4'h6) begin failures++; $display("FAIL single_owner: got %h expected 6", owner); end
        checks++; if (xfer_cnt !== 8'd1) begin failures++; $display("FAIL single_cnt: got %0d expected 1", xfer_cnt); end
        checks++; if (bus_busy !== 1'b1) begin failures++; $display("FAIL single_busy: got %b expected 1", bus_busy); end
        tick();
        tick();
        checks++; if (grant !== 16'h0040) begin failures++; $display("FAIL single_hold: got %h expected 0040", grant); end
        release_req = 16'h0040;
        tick();
        release_req = '0; valid = 1'b1; send_in = 4'h1;
        #1;
        checks++; if (grant !== 16'h0000) begin failures++; $display("FAIL single_revoke: got %h expected 0000", grant); end
        checks++; if (pull !== 1'b0) begin failures++; $display("FAIL single_turn_pull: got %b expected 0", pull); end
        checks++; if (bus_busy !== 1'b1) begin failures++; $display("FAIL single_turn_busy: got %b expected 1", bus_busy); end
        valid = 1'b0;
        tick();
        checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL single_idle_busy: got %b expected 0", bus_busy); end
        checks++; if (bus_idle !== 1'b1) begin failures++; $display("FAIL single_idle: got %b expected 1", bus_idle); end
        empty = 1'b0;
        #1;
        checks++; if (bus_idle !== 1'b0) begin failures++; $display("FAIL single_idle_nonempty: got %b expected 0", bus_idle); end
        empty = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [3:0]  ids [4] = '{4'h6, 4'h5, 4'h2, 4'h0};
        logic [15:0] exp [4] = '{16'h0040, 16'h0020, 16'h0004, 16'h0001};
        do_reset();
        valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            send_in = ids[i]; release_req = '0;
            #1;
            checks++; if (pull !== 1'b1) begin failures++; $display("FAIL b2b_pull%0d: got %b expected 1", i, pull); end
            tick();
            checks++; if (grant !== exp[i]) begin failures++; $display("FAIL b2b_grant%0d: got %h expected %h", i, grant, exp[i]); end
            checks++; if ($countones(grant) > 1) begin failures++; $display("FAIL b2b_onehot%0d: got %h expected at most one bit", i, grant); end
            release_req = exp[i];
            #1;
            checks++; if (pull !== 1'b0) begin failures++; $display("FAIL b2b_nopull_grant%0d: got %b expected 0", i, pull); end
            tick();
            checks++; if (pull !== 1'b0 || grant !== 16'h0000) begin failures++; $display("FAIL b2b_turn%0d: got pull=%b grant=%h expected 0/0000", i, pull, grant); end
            release_req = '0;
            tick();
        end
        valid = 1'b0;
        #1;
        checks++; if (xfer_cnt !== 8'd4) begin failures++; $display("FAIL b2b_cnt: got %0d expected 4", xfer_cnt); end
    endtask

    task automatic test_timeout();
        int n;
        do_reset();
        valid = 1'b1; send_in = 4'h9;
        tick();
        valid = 1'b0;
        n = 0;
        while (grant != 16'h0000 && n < 40) begin
            checks++; if (grant !== 16'h0200) begin failures++; $display("FAIL timeout_grant: got %h expected 0200", grant); end
            n++;
            tick();
        end
        checks++; if (n !== 32) begin failures++; $display("FAIL timeout_len: got %0d cycles expected 32", n); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err_set: got %b expected 1", timeout_err); end
        checks++; if (bus_busy !== 1'b1) begin failures++; $display("FAIL timeout_turn: got %b expected 1", bus_busy); end
        tick();
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL timeout_err_clr: got %b expected 0", timeout_err); end
        valid = 1'b1; send_in = 4'h3; err_clr = 1'b1;
        tick();
        valid = 1'b0;
        repeat (32) tick();
        err_clr = 1'b0;
        checks++; if (grant !== 16'h0000) begin failures++; $display("FAIL timeout2_revoke: got %h expected 0000", grant); end
        checks++; if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_set_wins: got %b expected 1", timeout_err); end
        tick();
    endtask

    task automatic test_foreign_release();
        do_reset();
        valid = 1'b1; send_in = 4'h2;
        tick();
        valid = 1'b0; release_req = 16'h0020;
        tick();
        checks++; if (grant !== 16'h0004) begin failures++; $display("FAIL foreign_ignored: got %h expected 0004", grant); end
        repeat (30) tick();
        checks++; if (grant !== 16'h0004) begin failures++; $display("FAIL foreign_last_cycle: got %h expected 0004", grant); end
        release_req = 16'h0024;
        tick();
        release_req = '0;
        checks++; if (grant !== 16'h0000) begin failures++; $display("FAIL simul_revoke: got %h expected 0000", grant); end
        checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL simul_err: got %b expected 0", timeout_err); end
        tick();
    endtask

    task automatic test_enable();
        do_reset();
        en = 1'b0; valid = 1'b1; send_in = 4'h7;
        #1;
        checks++; if (pull !== 1'b0) begin failures++; $display("FAIL en_block_pull: got %b expected 0", pull); end
        tick();
        tick();
        checks++; if (grant !== 16'h0000 || pull !== 1'b0) begin failures++; $display("FAIL en_block_grant: got grant=%h pull=%b expected 0000/0", grant, pull); end
        en = 1'b1;
        #1;
        checks++; if (pull !== 1'b1) begin failures++; $display("FAIL en_pull: got %b expected 1", pull); end
        tick();
        valid = 1'b0; en = 1'b0;
        tick();
        tick();
        checks++; if (grant !== 16'h0080) begin failures++; $display("FAIL en_mid_grant: got %h expected 0080", grant); end
        release_req = 16'h0080;
        tick();
        release_req = '0;
        checks++; if (grant !== 16'h0000) begin failures++; $display("FAIL en_release: got %h expected 0000", grant); end
        tick();
        en = 1'b1;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        valid = 1'b1; send_in = 4'hB;
        tick();
        valid = 1'b0;
        checks++; if (grant !== 16'h0800 || xfer_cnt !== 8'd1) begin failures++; $display("FAIL rmid_grant: got grant=%h cnt=%0d expected 0800/1", grant, xfer_cnt); end
        tick();
        valid = 1'b1;
        #2;
        clr = 1'b0;
        #1;
        checks++; if (grant !== 16'h0000) begin failures++; $display("FAIL rmid_grant_drop: got %h expected 0000", grant); end
        checks++; if (bus_busy !== 1'b0) begin failures++; $display("FAIL rmid_busy: got %b expected 0", bus_busy); end
        checks++; if (xfer_cnt !== 8'd0) begin failures++; $display("FAIL rmid_cnt: got %0d expected 0", xfer_cnt); end
        checks++; if (pull !== 1'b0) begin failures++; $display("FAIL rmid_pull: got %b expected 0", pull); end
        valid = 1'b0;
        #2;
        clr = 1'b1;
        tick();
        valid = 1'b1; send_in = 4'h3;
        #1;
        checks++; if (pull !== 1'b1) begin failures++; $display("FAIL rmid_repop_pull: got %b expected 1", pull); end
        tick();
        valid = 1'b0;
        checks++; if (grant !== 16'h0008 || xfer_cnt !== 8'd1) begin failures++; $display("FAIL rmid_repop: got grant=%h cnt=%0d expected 0008/1", grant, xfer_cnt); end
        release_req = 16'h0008;
        tick();
        release_req = '0;
        tick();
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_back_to_back();
        test_timeout();
        test_foreign_release();
        test_enable();
        test_reset_mid_grant();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/bus_grant_seq.md
Name: bus_grant_seq

Overview:
Downstream consumer of the bus request queue. Pops one queued sender ID at a time using a pull/valid handshake, and grants that agent exclusive bus ownership through a one-hot grant vector. Ownership ends on the owner's release or on a timeout, followed by one dead turnaround cycle before the next pop. The block also keeps a transfer counter and a sticky timeout error for debug and status.

Parameters:
NAGENT, 16, number of agents; grant vector width; must equal 2^IDW
IDW, 4, width of the sender ID from the queue
TIMEOUT, 32, maximum GRANT cycles before forced revoke; minimum 2
CNTW, 8, width of the transfer counter

Ports:
clk  in  1  system clock, rising-edge
clr  in  1  asynchronous active-low reset
en  in  1  enable; when low, no new pops start; an ongoing grant finishes normally
valid  in  1  queue head holds a grantable entry
empty  in  1  queue empty; status only, mirrored into bus_idle
send_in  in  IDW  sender ID at the queue head; meaningful only while valid=1
release  in  NAGENT  per-agent release request; only the current owner's bit is honoured
err_clr  in  1  synchronous clear of timeout_err
pull  out  1  pop strobe to the queue
grant  out  NAGENT  one-hot bus grant, registered
owner  out  IDW  ID of the current or last owner
bus_busy  out  1  high in GRANT and TURN states
bus_idle  out  1  state==IDLE and empty=1
timeout_err  out  1  sticky flag: a grant was revoked by timeout
xfer_cnt  out  CNTW  number of grants issued; wraps modulo 2^CNTW

Behaviour:
- Reset (clr=0, asynchronous):
  - state=IDLE; grant=0; owner=0; timeout_err=0; xfer_cnt=0; tcnt=0.
  - pull=0 and bus_busy=0 immediately.
  - A reset during GRANT drops grant asynchronously, with no turnaround cycle.
- States: IDLE, GRANT, TURN.
- IDLE:
  - pull = valid & en, combinational, and only ever asserted in IDLE.
  - On a rising edge with pull=1: owner<=send_in; grant<=1<<send_in; tcnt<=0; xfer_cnt<=xfer_cnt+1; go to GRANT.
  - Otherwise stay in IDLE.
- Latency: valid=1 at cycle n gives pull=1 in cycle n and grant visible in cycle n+1. At most one pull per grant cycle; the minimum spacing between pulls is 3 cycles.
- GRANT: grant holds the owner's one-hot; tcnt increments each cycle.
  - If release[owner]=1: go to TURN; grant<=0 at that edge.
  - Else if tcnt==TIMEOUT-1: go to TURN; grant<=0; timeout_err<=1.
  - If release[owner] and the timeout hit occur in the same cycle, release wins and timeout_err is not set.
  - Release bits of non-owners are ignored in every state.
- TURN: exactly one cycle with grant=0 and pull=0; then go to IDLE.
- Enable: en=0 blocks only the IDLE->GRANT transition. It never shortens a grant.
- timeout_err:
  - Cleared by err_clr=1 at the edge.
  - If a timeout set and err_clr fall on the same edge, the set wins.
- xfer_cnt wraps from 2^CNTW-1 to 0 with no flag.
- Invariant: grant is zero or one-hot at all times, and is nonzero only in GRANT.

Test Plan:
1. Reset and single grant: clr low 1 cycle then high; en=1; valid=1, send_in=4'h6 for 1 cycle -> pull=1 that cycle; next cycle grant=16'h0040, owner=6, xfer_cnt=1; release[6]=1 after 3 cycles -> grant=0 next cycle, one TURN cycle, then IDLE.
2. Back-to-back queue: valid held high with IDs 6,5,2,0 in sequence, each owner releasing after 1 GRANT cycle -> pulls spaced exactly 3 cycles apart; grants 0x0040, 0x0020, 0x0004, 0x0001; xfer_cnt=4; never two grant bits high.
3. Timeout: TIMEOUT=32, grant to ID 9, no release -> grant drops after exactly 32 GRANT cycles; timeout_err=1; err_clr pulse -> timeout_err=0.
4. Foreign release and simultaneity: owner ID 2, assert release[5] -> grant unchanged; assert release[2] on the same cycle tcnt==TIMEOUT-1 -> grant revoked and timeout_err stays 0.
5. Enable gating: en=0 with valid=1 -> pull stays 0, grant stays 0; en=1 -> pull in that same cycle; dropping en to 0 mid-GRANT does not revoke the grant.
6. Reset mid-grant: owner ID 11 granted, clr=0 asynchronously mid-cycle -> grant=0 and bus_busy=0 immediately, xfer_cnt=0; after release of reset the block pops again from IDLE.
